// File: rtl/uart_rx_fifo_if.sv
// Byte-receive / pop handshake between the UART receiver, the RX FIFO and the
// APB register block. master = receiver/register side, slave = FIFO.
interface uart_rx_fifo_if #(
  parameter int UART_DATA_WIDTH = 8,
  parameter int ADDR_WIDTH      = 4,
  parameter int TIMEOUT_WIDTH   = 32
);
  logic                       i_Rx_DV;
  logic [UART_DATA_WIDTH-1:0] i_Rx_Byte;
  logic                       i_Rd_En;
  logic                       i_Flush;
  logic                       i_Ovr_Clr;
  logic [ADDR_WIDTH:0]        i_Threshold;
  logic [TIMEOUT_WIDTH-1:0]   i_Timeout_Cycles;
  logic [UART_DATA_WIDTH-1:0] o_Rd_Data;
  logic                       o_Rd_Valid;
  logic                       o_Empty;
  logic                       o_Full;
  logic [ADDR_WIDTH:0]        o_Level;
  logic                       o_Overrun;
  logic                       o_Thresh_Irq;
  logic                       o_Timeout_Irq;

  modport master (
    output i_Rx_DV, i_Rx_Byte, i_Rd_En, i_Flush, i_Ovr_Clr, i_Threshold, i_Timeout_Cycles,
    input  o_Rd_Data, o_Rd_Valid, o_Empty, o_Full, o_Level, o_Overrun, o_Thresh_Irq, o_Timeout_Irq
  );

  modport slave (
    input  i_Rx_DV, i_Rx_Byte, i_Rd_En, i_Flush, i_Ovr_Clr, i_Threshold, i_Timeout_Cycles,
    output o_Rd_Data, o_Rd_Valid, o_Empty, o_Full, o_Level, o_Overrun, o_Thresh_Irq, o_Timeout_Irq
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Circular receive FIFO behind the UART receiver: 1-cycle pop, fill level,
// sticky overrun, fill-threshold and character-timeout interrupts.
module uart_rx_fifo #(
  parameter int UART_DATA_WIDTH = 8,
  parameter int FIFO_DEPTH      = 16,
  parameter int ADDR_WIDTH      = 4,
  parameter int TIMEOUT_WIDTH   = 32
) (
  input logic           i_Clock,
  input logic           i_Reset,
  uart_rx_fifo_if.slave bus
);
  localparam logic [ADDR_WIDTH:0]      DEPTH_L = (ADDR_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0]      LVL_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0]    PTR_ONE = ADDR_WIDTH'(1);
  localparam logic [TIMEOUT_WIDTH-1:0] TO_ONE  = TIMEOUT_WIDTH'(1);

  logic [UART_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]      wptr_q, rptr_q;
  logic [ADDR_WIDTH:0]        level_q;
  logic [TIMEOUT_WIDTH-1:0]   to_cnt_q;
  logic [UART_DATA_WIDTH-1:0] rd_data_q;
  logic                       rd_valid_q, ovr_q, to_irq_q;
  logic                       empty, full, pop_acc, push_acc, ovr_set, to_clr;

  assign empty = (level_q == '0);
  assign full  = (level_q == DEPTH_L);

  // Flush discards both sides; a full FIFO still takes a byte if a pop frees a slot.
  assign pop_acc  = bus.i_Rd_En && !empty && !bus.i_Flush;
  assign push_acc = bus.i_Rx_DV && (!full || pop_acc) && !bus.i_Flush;
  assign ovr_set  = bus.i_Rx_DV && full && !pop_acc && !bus.i_Flush;
  assign to_clr   = bus.i_Flush || empty || push_acc || pop_acc;

  always_ff @(posedge i_Clock)
    if (push_acc) mem[wptr_q] <= bus.i_Rx_Byte;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      to_cnt_q   <= '0;
      to_irq_q   <= 1'b0;
      ovr_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= pop_acc;
      if (pop_acc) begin
        rd_data_q <= mem[rptr_q];
        rptr_q    <= rptr_q + PTR_ONE;
      end
      if (push_acc) wptr_q <= wptr_q + PTR_ONE;

      if (bus.i_Flush) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        level_q <= '0;
      end else if (push_acc && !pop_acc) begin
        level_q <= level_q + LVL_ONE;
      end else if (pop_acc && !push_acc) begin
        level_q <= level_q - LVL_ONE;
      end

      // Set beats clear so a drop in the clearing cycle is never lost.
      if (ovr_set)            ovr_q <= 1'b1;
      else if (bus.i_Ovr_Clr) ovr_q <= 1'b0;

      if (to_clr) begin
        to_cnt_q <= '0;
        to_irq_q <= 1'b0;
      end else begin
        if (to_cnt_q < bus.i_Timeout_Cycles) to_cnt_q <= to_cnt_q + TO_ONE;
        if (bus.i_Timeout_Cycles == '0)
          to_irq_q <= 1'b0;
        else if (to_cnt_q == bus.i_Timeout_Cycles)
          to_irq_q <= 1'b1;
      end
    end
  end

  assign bus.o_Rd_Data     = rd_data_q;
  assign bus.o_Rd_Valid    = rd_valid_q;
  assign bus.o_Empty       = empty;
  assign bus.o_Full        = full;
  assign bus.o_Level       = level_q;
  assign bus.o_Overrun     = ovr_q;
  // Disabling the timeout drops a pending interrupt without waiting a cycle.
  assign bus.o_Timeout_Irq = to_irq_q && (bus.i_Timeout_Cycles != '0);
  assign bus.o_Thresh_Irq  = (bus.i_Threshold != '0) && (level_q >= bus.i_Threshold);
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: FIFO order, overrun, simultaneous push/pop,
// pointer wrap, threshold/timeout interrupts, flush and async reset.
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  uart_rx_fifo_if #(.UART_DATA_WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT_WIDTH(32)) bus ();

  uart_rx_fifo #(.UART_DATA_WIDTH(8), .FIFO_DEPTH(16), .ADDR_WIDTH(4), .TIMEOUT_WIDTH(32)) dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    bus.i_Rx_DV = 1'b1; bus.i_Rx_Byte = b;
    tick();
    bus.i_Rx_DV = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    bus.i_Rd_En = 1'b1;
    tick();
    bus.i_Rd_En = 1'b0;
    chk({tag, "_vld"}, 32'(bus.o_Rd_Valid), 32'd1);
    chk({tag, "_dat"}, 32'(bus.o_Rd_Data), 32'(exp));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_lvl"},   32'(bus.o_Level), 32'd0);
    chk({tag, "_empty"}, 32'(bus.o_Empty), 32'd1);
    chk({tag, "_full"},  32'(bus.o_Full), 32'd0);
    chk({tag, "_vld"},   32'(bus.o_Rd_Valid), 32'd0);
    chk({tag, "_dat"},   32'(bus.o_Rd_Data), 32'd0);
    chk({tag, "_ovr"},   32'(bus.o_Overrun), 32'd0);
    chk({tag, "_thr"},   32'(bus.o_Thresh_Irq), 32'd0);
    chk({tag, "_to"},    32'(bus.o_Timeout_Irq), 32'd0);
  endtask

  initial begin
    int lvl, npop;
    bus.i_Rx_DV = 0; bus.i_Rx_Byte = '0; bus.i_Rd_En = 0; bus.i_Flush = 0;
    bus.i_Ovr_Clr = 0; bus.i_Threshold = '0; bus.i_Timeout_Cycles = '0;

    tick(); tick();
    chk_reset_state("rst");
    rst = 1'b0;
    tick();

    // three bytes in, three out in order
    push(8'h41); push(8'h42); push(8'h43);
    chk("t1_lvl3", 32'(bus.o_Level), 32'd3);
    pop_chk("t1_p0", 8'h41);
    tick();
    chk("t1_pulse", 32'(bus.o_Rd_Valid), 32'd0);
    pop_chk("t1_p1", 8'h42);
    pop_chk("t1_p2", 8'h43);
    chk("t1_empty", 32'(bus.o_Empty), 32'd1);
    bus.i_Rd_En = 1'b1; tick(); bus.i_Rd_En = 1'b0;
    chk("t1_pope_vld", 32'(bus.o_Rd_Valid), 32'd0);
    chk("t1_pope_dat", 32'(bus.o_Rd_Data), 32'h43);

    // fill, overrun, set-wins-over-clear
    for (int i = 0; i < 16; i++) push(8'(i));
    chk("t2_full", 32'(bus.o_Full), 32'd1);
    chk("t2_noovr", 32'(bus.o_Overrun), 32'd0);
    push(8'h10);
    chk("t2_ovr", 32'(bus.o_Overrun), 32'd1);
    chk("t2_lvl16", 32'(bus.o_Level), 32'd16);
    bus.i_Ovr_Clr = 1'b1; push(8'h11); bus.i_Ovr_Clr = 1'b0;
    chk("t2_setwins", 32'(bus.o_Overrun), 32'd1);
    for (int i = 0; i < 16; i++) pop_chk("t2_pop", 8'(i));
    chk("t2_empty", 32'(bus.o_Empty), 32'd1);
    chk("t2_ovr_hold", 32'(bus.o_Overrun), 32'd1);
    bus.i_Ovr_Clr = 1'b1; tick(); bus.i_Ovr_Clr = 1'b0;
    chk("t2_ovr_clr", 32'(bus.o_Overrun), 32'd0);

    // push+pop while full
    for (int i = 0; i < 16; i++) push(8'h80 + 8'(i));
    bus.i_Rd_En = 1'b1; push(8'hAA); bus.i_Rd_En = 1'b0;
    chk("t3_vld", 32'(bus.o_Rd_Valid), 32'd1);
    chk("t3_dat", 32'(bus.o_Rd_Data), 32'h80);
    chk("t3_lvl", 32'(bus.o_Level), 32'd16);
    chk("t3_ovr", 32'(bus.o_Overrun), 32'd0);
    for (int i = 1; i < 16; i++) pop_chk("t3_pop", 8'h80 + 8'(i));
    pop_chk("t3_last", 8'hAA);

    // push+pop while empty
    bus.i_Rd_En = 1'b1; push(8'h55); bus.i_Rd_En = 1'b0;
    chk("t4_vld", 32'(bus.o_Rd_Valid), 32'd0);
    chk("t4_lvl", 32'(bus.o_Level), 32'd1);
    pop_chk("t4_pop", 8'h55);

    // 24 in / 20 out across the pointer wrap
    lvl = 0; npop = 0;
    for (int i = 0; i < 24; i++) begin
      push(8'h60 + 8'(i)); lvl++;
      chk("t5_lvl_push", 32'(bus.o_Level), 32'(lvl));
      if (lvl >= 8 && npop < 20) begin
        pop_chk("t5_pop", 8'h60 + 8'(npop)); npop++; lvl--;
        chk("t5_lvl_pop", 32'(bus.o_Level), 32'(lvl));
      end
    end
    while (npop < 20) begin
      pop_chk("t5_tail", 8'h60 + 8'(npop)); npop++; lvl--;
    end
    chk("t5_lvl4", 32'(bus.o_Level), 32'd4);
    bus.i_Flush = 1'b1; tick(); bus.i_Flush = 1'b0;
    chk("t5_flush", 32'(bus.o_Level), 32'd0);

    // threshold and timeout interrupts
    bus.i_Threshold = 5'd4; bus.i_Timeout_Cycles = 32'd10;
    push(8'hC0); push(8'hC1);
    chk("t6_thr0", 32'(bus.o_Thresh_Irq), 32'd0);
    for (int k = 1; k <= 10; k++) tick();
    chk("t6_to_10", 32'(bus.o_Timeout_Irq), 32'd0);
    tick();
    chk("t6_to_11", 32'(bus.o_Timeout_Irq), 32'd1);
    tick();
    chk("t6_to_hold", 32'(bus.o_Timeout_Irq), 32'd1);
    pop_chk("t6_pop", 8'hC0);
    chk("t6_to_drop", 32'(bus.o_Timeout_Irq), 32'd0);
    push(8'hC2); push(8'hC3);
    chk("t6_thr_l3", 32'(bus.o_Thresh_Irq), 32'd0);
    push(8'hC4);
    chk("t6_thr_l4", 32'(bus.o_Thresh_Irq), 32'd1);
    for (int k = 1; k <= 11; k++) tick();
    chk("t6_to_again", 32'(bus.o_Timeout_Irq), 32'd1);
    bus.i_Flush = 1'b1; bus.i_Rd_En = 1'b1; push(8'hEE);
    bus.i_Flush = 1'b0; bus.i_Rd_En = 1'b0;
    chk("t6_fl_lvl", 32'(bus.o_Level), 32'd0);
    chk("t6_fl_vld", 32'(bus.o_Rd_Valid), 32'd0);
    chk("t6_fl_thr", 32'(bus.o_Thresh_Irq), 32'd0);
    chk("t6_fl_to", 32'(bus.o_Timeout_Irq), 32'd0);

    // async reset mid-fill
    push(8'h11); push(8'h22); push(8'h33);
    pop_chk("t7_pop", 8'h11);
    rst = 1'b1;
    #2;
    chk_reset_state("t7_rst");
    tick();
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive buffer that sits directly downstream of the UART receiver.
- Captures each byte presented with the receiver's one-cycle data-valid pulse into a circular FIFO.
- Exposes a pop interface to the APB slave register block.
- Reports fill level, sticky overrun, a fill-threshold interrupt and a character-timeout interrupt, so software need not poll per byte.

Parameters:
UART_DATA_WIDTH, 8, width of each received byte
FIFO_DEPTH, 16, number of entries; power of two, minimum 2
ADDR_WIDTH, 4, log2(FIFO_DEPTH); pointer width
TIMEOUT_WIDTH, 32, width of timeout counter and its configuration input

Ports:
i_Clock  in  1  system clock; all logic on rising edge
i_Reset  in  1  asynchronous, active-high reset
i_Rx_DV  in  1  one-cycle byte-valid pulse from UART receiver
i_Rx_Byte  in  UART_DATA_WIDTH  received byte, valid when i_Rx_DV=1
i_Rd_En  in  1  pop request from register block
i_Flush  in  1  synchronous clear of FIFO contents
i_Ovr_Clr  in  1  clears sticky overrun flag
i_Threshold  in  ADDR_WIDTH+1  threshold-interrupt level; 0 disables
i_Timeout_Cycles  in  TIMEOUT_WIDTH  idle cycles before timeout interrupt; 0 disables
o_Rd_Data  out  UART_DATA_WIDTH  popped byte
o_Rd_Valid  out  1  one-cycle pulse: o_Rd_Data updated
o_Empty  out  1  level == 0
o_Full  out  1  level == FIFO_DEPTH
o_Level  out  ADDR_WIDTH+1  current entry count, 0..FIFO_DEPTH
o_Overrun  out  1  sticky: byte dropped because FIFO full
o_Thresh_Irq  out  1  level >= i_Threshold and i_Threshold != 0
o_Timeout_Irq  out  1  data waiting with no activity for i_Timeout_Cycles

Behaviour:
- Reset values:
  - Pointers, level, o_Rd_Data, o_Rd_Valid, o_Overrun, o_Timeout_Irq and timeout counter = 0.
  - o_Empty = 1; o_Full = 0; o_Thresh_Irq = 0.
  - Reset mid-operation discards all contents immediately.
- Storage:
  - Write and read pointers are ADDR_WIDTH bits and wrap naturally at FIFO_DEPTH.
  - Level is a separate ADDR_WIDTH+1 counter.
  - o_Empty, o_Full and o_Thresh_Irq are combinational from the registered level and i_Threshold.
- Push:
  - i_Rx_DV=1 and not full: store byte at the write pointer; pointer+1; level+1, visible next cycle.
- Pop:
  - i_Rd_En=1 and not empty: o_Rd_Data <= mem[read pointer] and o_Rd_Valid=1 in the next cycle; read pointer+1; level-1.
  - Pop latency is 1 cycle.
  - Pop when empty is ignored: o_Rd_Valid stays 0 and o_Rd_Data holds its last value.
- Simultaneous push and pop:
  - Non-empty, non-full: both occur; level unchanged.
  - Full: both occur; no overrun; level stays FIFO_DEPTH.
  - Empty: the pop is ignored; the push succeeds; level becomes 1.
- Overrun:
  - Push when full with no pop in the same cycle drops the byte and sets o_Overrun.
  - o_Overrun holds until i_Ovr_Clr=1.
  - Simultaneous i_Ovr_Clr and a new overrun event leaves o_Overrun=1 (set wins).
- Flush:
  - i_Flush=1 zeroes pointers, level, timeout counter and o_Timeout_Irq.
  - Flush has priority over a push or pop in the same cycle; both are discarded and o_Rd_Valid=0.
  - Flush does not clear o_Overrun.
- Timeout counter:
  - Cleared when the FIFO is empty, on any accepted push, on any accepted pop, or on flush.
  - Otherwise increments each cycle and saturates at i_Timeout_Cycles.
  - o_Timeout_Irq is registered and asserts the cycle after the counter equals i_Timeout_Cycles, provided i_Timeout_Cycles != 0.
  - o_Timeout_Irq stays high until the next counter-clearing event.
  - i_Timeout_Cycles=0 forces o_Timeout_Irq=0.
- Configuration inputs are sampled every cycle; a change takes effect immediately.

Test Plan:
- Reset, then push 0x41, 0x42, 0x43 on separate pulses -> o_Level=3. Three pops -> o_Rd_Valid pulses 1 cycle after each i_Rd_En with data 0x41, 0x42, 0x43 in order; o_Empty=1 at the end.
- Push 17 bytes 0x00..0x10 with FIFO_DEPTH=16 -> o_Full=1 after the 16th, o_Overrun=1 after the 17th. Pop all -> 0x00..0x0F (0x10 dropped). i_Ovr_Clr -> o_Overrun=0.
- Fill to full, then push and pop in the same cycle -> o_Level stays 16, o_Overrun=0. Popped byte is the oldest; the new byte is read last.
- Empty FIFO, push and pop in the same cycle -> o_Rd_Valid=0, o_Level=1.
- Push 24 then pop 20 across the pointer wrap (pop whenever level>=8) -> data order preserved, o_Level correct at every step.
- i_Threshold=4, i_Timeout_Cycles=10; push 2 bytes then idle:
  - o_Thresh_Irq stays 0; o_Timeout_Irq rises 11 cycles after the last push.
  - One pop drops o_Timeout_Irq.
  - Push 3 more -> o_Thresh_Irq=1 at level 4.
  - i_Flush -> level 0, both interrupts 0.
  - Assert i_Reset mid-fill -> all outputs at reset values.
